// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and buffered fetch entries.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush; DEPTH must be a power of two.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking (<=) assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is reset (not just the pointers) because the head entry drives
  // id_instr/id_pc directly and those must read zero out of reset; a large RAM
  // would normally be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ARM64 instruction fetch stage: one outstanding imem read, buffered results to decode.
// Optional decode-bubble counter built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [31:0] perf_bubbles
);

  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(IBUF_DEPTH);

  fetch_state_t     state;
  logic [63:0]      pc;
  logic [63:0]      req_pc;
  logic [CNT_W-1:0] count;
  logic             slot_free;
  logic             granted;
  logic             push;
  logic             pop;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // Only REQ issues; with one request in flight a free slot now is a slot reserved for its response.
  assign slot_free  = count < DEPTH_COUNT;
  assign imem_req   = !reset && (state == REQ) && slot_free && !redirect_valid;
  assign imem_addr  = pc;
  assign granted    = imem_req && imem_gnt;
  assign push       = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop        = id_valid && !stall_id;
  assign push_entry = '{pc: req_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[63:2], 2'b00};
      case (state)
        REQ:     state <= imem_gnt ? DROP : REQ;
        WAIT:    state <= imem_rvalid ? REQ : DROP;
        DROP:    state <= imem_rvalid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (granted) begin
            req_pc <= pc;
            pc     <= pc + 64'(INSTR_BYTES);
            state  <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state <= REQ;
        DROP:    if (imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH(IBUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign id_valid = count != '0;
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] bubbles;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubbles <= '0;
    end else if (!id_valid && !stall_id && (bubbles != 32'hFFFF_FFFF)) begin
      bubbles <= bubbles + 32'd1;
    end
  end

  assign perf_bubbles = bubbles;
`else
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases, a small imem responder, and a scoreboard monitor on decode output.
module tb_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd7;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [31:0] perf_bubbles;

  int total = 0;
  int bad = 0;
  int retired = 0;
  int pend_cnt = 0;
  int resp_lat = 1;
  int gnt_hold = 0;
  logic [63:0] pend_addr = '0;
  fetch_entry_t exp_q[$];

  fetch_unit #(
    .RESET_PC   (64'h0),
    .IBUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .perf_bubbles   (perf_bubbles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'h9100_0421 + a[31:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] instr);
    exp_q.push_back('{pc: pc, instr: instr});
  endtask

  // Instruction memory: grants when idle, answers resp_lat cycles after the grant.
  always begin
    @(negedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr);
      end
    end
    if (pend_cnt != 0) check("one_outstanding", 64'(imem_req), 64'd0);
    if (gnt_hold > 0) begin
      gnt_hold--;
    end else if (imem_req && pend_cnt == 0) begin
      imem_gnt  = 1'b1;
      pend_cnt  = resp_lat;
      pend_addr = imem_addr;
    end
  end

  // Scoreboard monitor: every instruction decode accepts must match the next expected entry.
  always begin
    @(negedge clk);
    #2;
    if (!reset && id_valid && !stall_id) begin
      check("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        check("sb_id_pc", id_pc, e.pc);
        check("sb_id_instr", 64'(id_instr), 64'(e.instr));
      end
      retired++;
    end
  end

  task automatic do_reset(input int lat, input int hold, input logic stall);
    reset          = 1'b1;
    stall_id       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend_cnt       = 0;
    gnt_hold       = 0;
    retired        = 0;
    exp_q.delete();
    step();
    step();
    #2;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_imem_addr", imem_addr, 64'h0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_instr", 64'(id_instr), 64'd0);
    check("rst_id_pc", id_pc, 64'h0);
    check("rst_perf", 64'(perf_bubbles), 64'd0);
    step();
    reset    = 1'b0;
    stall_id = stall;
    resp_lat = lat;
    gnt_hold = hold;
  endtask

  task automatic wait_retired(input int n);
    int cyc;
    cyc = 0;
    while (retired < n && cyc < 200) begin
      step();
      cyc++;
    end
    stall_id = 1'b1;
    check("retired_count", 64'(retired), 64'(n));
  endtask

  initial begin
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    reset          = 1'b1;
    stall_id       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Zero-wait memory: one instruction every two cycles.
    do_reset(1, 0, 1'b0);
    expect_entry(64'h0, 32'h9100_0421);
    expect_entry(64'h4, 32'h9100_0425);
    expect_entry(64'h8, 32'h9100_0429);
    expect_entry(64'hC, 32'h9100_042D);
    #2;
    check("t1_c0_req", 64'(imem_req), 64'd1);
    check("t1_c0_addr", imem_addr, 64'h0);
    step(); #2;
    check("t1_c1_req", 64'(imem_req), 64'd0);
    check("t1_c1_valid", 64'(id_valid), 64'd0);
    step(); #2;
    check("t1_c2_valid", 64'(id_valid), 64'd1);
    check("t1_c2_addr", imem_addr, 64'h4);
    step(); #2;
    check("t1_c3_valid", 64'(id_valid), 64'd0);
    step(); #2;
    check("t1_c4_valid", 64'(id_valid), 64'd1);
    check("t1_c4_addr", imem_addr, 64'h8);
    wait_retired(4);

    // Decode stalled for 10 cycles: buffer fills, requests stop, head stays put.
    do_reset(1, 0, 1'b1);
    expect_entry(64'h0, 32'h9100_0421);
    expect_entry(64'h4, 32'h9100_0425);
    expect_entry(64'h8, 32'h9100_0429);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      #2;
      if (c >= 4) check("t2_req_blocked", 64'(imem_req), 64'd0);
      if (c >= 2) begin
        check("t2_valid_held", 64'(id_valid), 64'd1);
        check("t2_pc_held", id_pc, 64'h0);
      end
    end
    step();
    stall_id = 1'b0;
    #2;
    check("t2_c10_req", 64'(imem_req), 64'd0);
    step(); #2;
    check("t2_c11_req", 64'(imem_req), 64'd1);
    check("t2_c11_addr", imem_addr, 64'h8);
    check("t2_c11_pc", id_pc, 64'h4);
    wait_retired(3);

    // Redirect while waiting; the stale response lands a cycle later and is dropped.
    do_reset(2, 0, 1'b0);
    expect_entry(64'h1000, 32'h9100_1421);
    expect_entry(64'h1004, 32'h9100_1425);
    #2;
    check("t3_c0_addr", imem_addr, 64'h0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    #2;
    check("t3_c1_req", 64'(imem_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    #2;
    check("t3_c2_req", 64'(imem_req), 64'd0);
    check("t3_c2_valid", 64'(id_valid), 64'd0);
    step(); #2;
    check("t3_c3_req", 64'(imem_req), 64'd1);
    check("t3_c3_addr", imem_addr, 64'h1000);
    check("t3_c3_valid", 64'(id_valid), 64'd0);
    wait_retired(2);

    // Redirect coincident with a response while one entry is buffered: both are discarded.
    do_reset(1, 0, 1'b1);
    expect_entry(64'h1000, 32'h9100_1421);
    expect_entry(64'h1004, 32'h9100_1425);
    step(); step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    #2;
    check("t4_c3_valid", 64'(id_valid), 64'd1);
    check("t4_c3_pc", id_pc, 64'h0);
    check("t4_c3_req", 64'(imem_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    stall_id       = 1'b0;
    #2;
    check("t4_c4_valid", 64'(id_valid), 64'd0);
    check("t4_c4_req", 64'(imem_req), 64'd1);
    check("t4_c4_addr", imem_addr, 64'h1000);
    wait_retired(2);

    // Push and pop in the same cycle at count 1.
    do_reset(1, 0, 1'b1);
    expect_entry(64'h0, 32'h9100_0421);
    expect_entry(64'h4, 32'h9100_0425);
    expect_entry(64'h8, 32'h9100_0429);
    expect_entry(64'hC, 32'h9100_042D);
    step(); step(); step();
    stall_id = 1'b0;
    #2;
    check("t5_c3_pc", id_pc, 64'h0);
    step(); #2;
    check("t5_c4_valid", 64'(id_valid), 64'd1);
    check("t5_c4_pc", id_pc, 64'h4);
    check("t5_c4_req", 64'(imem_req), 64'd1);
    check("t5_c4_addr", imem_addr, 64'h8);
    wait_retired(4);

    // Grant held off for 5 cycles: bubble counter at the first valid instruction.
    do_reset(1, 5, 1'b0);
    expect_entry(64'h0, 32'h9100_0421);
    expect_entry(64'h4, 32'h9100_0425);
    #2;
    check("t6_c0_perf", 64'(perf_bubbles), 64'd0);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      #2;
      check("t6_no_valid", 64'(id_valid), 64'd0);
    end
    step(); #2;
    check("t6_c7_valid", 64'(id_valid), 64'd1);
    check("t6_c7_perf", 64'(perf_bubbles), 64'(PERF_EXP));
    wait_retired(2);

    // Redirect near the top of the address space: low bits cleared, PC wraps to zero.
    do_reset(1, 0, 1'b0);
    expect_entry(64'hFFFF_FFFF_FFFF_FFFC, 32'h9100_041D);
    expect_entry(64'h0, 32'h9100_0421);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    check("t7_c0_req", 64'(imem_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    #2;
    check("t7_c1_req", 64'(imem_req), 64'd1);
    check("t7_c1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_retired(2);

    // Reset mid-transaction: the late response arrives in REQ and must be ignored.
    do_reset(2, 0, 1'b0);
    expect_entry(64'h0, 32'h9100_0421);
    step();
    reset    = 1'b1;
    stall_id = 1'b1;
    #2;
    check("t8_c1_req", 64'(imem_req), 64'd0);
    step();
    reset    = 1'b0;
    stall_id = 1'b0;
    gnt_hold = 1;
    #2;
    check("t8_c2_req", 64'(imem_req), 64'd1);
    check("t8_c2_addr", imem_addr, 64'h0);
    for (int c = 3; c < 6; c++) begin
      step(); #2;
      check("t8_no_stale_valid", 64'(id_valid), 64'd0);
    end
    wait_retired(1);
    step(); step();
    check("t8_no_extra", 64'(retired), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
